// File: rtl/pipeline_operand_forward.sv
// F/D, D/E and E/M pipeline registers with decode-stage operand forwarding,
// bubble insertion on stall/flush and a saturating stall-cycle counter.
module pipeline_operand_forward #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int REGISTER_SIZE = 5,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_to_d_enable_ff,
    input  logic                     d_to_e_enable_ff,
    input  logic [1:0][1:0]          pipeline_forward_sel,
    input  logic                     branch_flush,
    input  logic [31:0]              fetch_instr,
    input  logic [ADDR_WIDTH-1:0]    fetch_pc,
    output logic [31:0]              decode_instr,
    output logic [ADDR_WIDTH-1:0]    decode_pc,
    output logic                     decode_valid,
    input  logic [REGISTER_SIZE-1:0] decode_source_reg1,
    input  logic [REGISTER_SIZE-1:0] decode_source_reg2,
    input  logic [REGISTER_SIZE-1:0] decode_destination_reg,
    input  logic                     decode_dm_read_enable,
    input  logic                     decode_rf_write_enable,
    input  logic [DATA_WIDTH-1:0]    rf_data_a,
    input  logic [DATA_WIDTH-1:0]    rf_data_b,
    input  logic [DATA_WIDTH-1:0]    execute_alu_result,
    input  logic [DATA_WIDTH-1:0]    mem_dm_read_data,
    output logic [DATA_WIDTH-1:0]    execute_operand_a,
    output logic [DATA_WIDTH-1:0]    execute_operand_b,
    output logic [REGISTER_SIZE-1:0] execute_destination_reg,
    output logic                     execute_dm_read_enable,
    output logic                     execute_rf_write_enable,
    output logic                     execute_valid,
    output logic [DATA_WIDTH-1:0]    mem_alu_result,
    output logic [REGISTER_SIZE-1:0] mem_destination_reg,
    output logic                     mem_rf_write_enable,
    output logic                     mem_valid,
    output logic [COUNT_WIDTH-1:0]   stall_count
);

    typedef enum logic [1:0] {
        DECODE_RF_OPERAND      = 2'd0,
        MEM_ACCESS_DM_OPERAND  = 2'd1,
        EXECUTE_ALU_OPERAND    = 2'd2,
        MEM_ACCESS_ALU_OPERAND = 2'd3
    } fwd_sel_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [DATA_WIDTH-1:0] fwd_operand_a;
    logic [DATA_WIDTH-1:0] fwd_operand_b;
    logic                  bubble;
    logic                  stall_cycle;

    function automatic logic [DATA_WIDTH-1:0] pick_operand(
        input logic [1:0]               sel,
        input logic [REGISTER_SIZE-1:0] src,
        input logic [DATA_WIDTH-1:0]    rf_value
    );
        logic [DATA_WIDTH-1:0] value;
        value = rf_value;
        unique case (fwd_sel_e'(sel))
            DECODE_RF_OPERAND:      value = rf_value;
            MEM_ACCESS_DM_OPERAND:  value = mem_dm_read_data;
            EXECUTE_ALU_OPERAND:    value = execute_alu_result;
            MEM_ACCESS_ALU_OPERAND: value = mem_alu_result;
        endcase
        // x0 is hardwired zero, so never forward a result into it
        if (src == '0) value = rf_value;
        return value;
    endfunction

    always_comb begin
        fwd_operand_a = pick_operand(pipeline_forward_sel[0],
                                     decode_source_reg1, rf_data_a);
        fwd_operand_b = pick_operand(pipeline_forward_sel[1],
                                     decode_source_reg2, rf_data_b);
    end

    assign bubble      = branch_flush | ~d_to_e_enable_ff;
    assign stall_cycle = ~branch_flush & ~d_to_e_enable_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            decode_instr <= '0;
            decode_pc    <= '0;
            decode_valid <= 1'b0;
        end else if (branch_flush) begin
            decode_instr <= NOP_INSTR;
            decode_pc    <= '0;
            decode_valid <= 1'b0;
        end else if (f_to_d_enable_ff) begin
            decode_instr <= fetch_instr;
            decode_pc    <= fetch_pc;
            decode_valid <= 1'b1;
        end
    end

    // A stall bubbles D/E rather than holding it so the load ahead drains
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            execute_operand_a       <= '0;
            execute_operand_b       <= '0;
            execute_destination_reg <= '0;
            execute_dm_read_enable  <= 1'b0;
            execute_rf_write_enable <= 1'b0;
            execute_valid           <= 1'b0;
        end else begin
            execute_operand_a       <= fwd_operand_a;
            execute_operand_b       <= fwd_operand_b;
            execute_destination_reg <= decode_destination_reg;
            execute_dm_read_enable  <= decode_dm_read_enable;
            execute_rf_write_enable <= decode_rf_write_enable;
            execute_valid           <= decode_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_alu_result      <= '0;
            mem_destination_reg <= '0;
            mem_rf_write_enable <= 1'b0;
            mem_valid           <= 1'b0;
        end else begin
            mem_alu_result      <= execute_alu_result;
            mem_destination_reg <= execute_destination_reg;
            mem_rf_write_enable <= execute_rf_write_enable;
            mem_valid           <= execute_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_cycle && stall_count != '1) begin
            stall_count <= stall_count + COUNT_WIDTH'(1);
        end
    end

endmodule
